// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM encoding and default character width.
package uart_pkg;

  localparam int DBITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular register-array FIFO with occupancy count; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEF,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [DBITS-1:0] wdata,
  input  logic             pop,
  output logic [DBITS-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int CNT_W = AW + 1;
  localparam logic [AW:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = CNT_W'(1);

  logic [DBITS-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr & (~full | pop);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter: bus writes fill a FIFO and a
// drain FSM hands one byte at a time to the transmitter via a held wr_en request.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEF,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PWRITE,
  input  logic [DBITS-1:0] PWDATA,
  input  logic             tx_busy,
  output logic             tx_wr_en,
  output logic [DBITS-1:0] tx_din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf
);

  drain_state_e state_q;
  drain_state_e state_d;
  logic         pop;

  // The transmitter raising busy while we request is the load acknowledge.
  assign pop      = (state_q == REQ) & tx_busy;
  assign tx_wr_en = (state_q == REQ);

  sync_fifo #(
    .DBITS (DBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .wr    (PWRITE),
    .wdata (PWDATA),
    .pop   (pop),
    .rdata (tx_din),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = REQ;
      REQ:       if (tx_busy)            state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy)           state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // A dropped push outranks a simultaneous clear so no loss goes unreported.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                      overflow <= 1'b0;
    else if (PWRITE && full && !pop)   overflow <= 1'b1;
    else if (clr_ovf)                  overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       tx_busy;
  logic       clr_ovf;
  logic       tx_wr_en;
  logic [7:0] tx_din;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  uart_tx_fifo dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .tx_busy  (tx_busy),
    .tx_wr_en (tx_wr_en),
    .tx_din   (tx_din),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue plus request/waiting flags of the handshake.
  logic [7:0] q[$];
  logic [7:0] dut_log[$];
  bit         m_req;
  bit         m_wait;
  bit         m_ovf;
  int         max_cnt;

  // Transmitter model driving tx_busy.
  int tx_delay;
  int tx_len;
  int wait_cnt;
  int busy_left;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       clr;
    int         ecount;
    logic       ereq;
    logic       eovf;
    logic [7:0] edin;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req     = 1'b0;
    m_wait    = 1'b0;
    m_ovf     = 1'b0;
    wait_cnt  = 0;
    busy_left = 0;
  endtask

  // Compare outputs against the model, advance the model with current inputs, clock once.
  task automatic cycle();
    bit was_full;
    bit was_empty;
    bit pop;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("tx_wr_en", 32'(tx_wr_en), 32'(m_req));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_req) chk("tx_din", 32'(tx_din), 32'(q[0]));
    if (32'(count) > max_cnt) max_cnt = 32'(count);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    pop       = m_req && tx_busy;
    if (pop) begin
      dut_log.push_back(tx_din);
      void'(q.pop_front());
    end
    if (PWRITE && (!was_full || pop)) q.push_back(PWDATA);
    if (PWRITE && was_full && !pop) m_ovf = 1'b1;
    else if (clr_ovf)               m_ovf = 1'b0;
    if (m_req) begin
      m_req  = !tx_busy;
      m_wait = tx_busy;
    end else if (m_wait) begin
      m_wait = tx_busy;
    end else begin
      m_req = !was_empty && !tx_busy;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic busy, input logic clr);
    PWRITE  = wr;
    PWDATA  = d;
    tx_busy = busy;
    clr_ovf = clr;
    cycle();
  endtask

  task automatic step_tx(input logic wr, input logic [7:0] d, input logic clr);
    logic b;
    b = 1'b0;
    if (busy_left > 0) begin
      b = 1'b1;
      busy_left--;
    end else if (tx_wr_en) begin
      if (wait_cnt >= tx_delay) begin
        b         = 1'b1;
        busy_left = tx_len - 1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
    step(wr, d, b, clr);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((q.size() != 0 || m_req || m_wait || busy_left > 0) && n < max_cyc) begin
      step_tx(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_in_time", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'hA5};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'hA5};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h7E, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h3C};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'h7E};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00};

    PRESETn = 1'b0;
    PWRITE  = 1'b0;
    PWDATA  = 8'h00;
    tx_busy = 1'b0;
    clr_ovf = 1'b0;
    tx_delay = 0;
    tx_len   = 1;
    max_cnt  = 0;
    model_reset();
    #22;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Vector table from idle.
    for (int i = 0; i < 14; i++) begin
      PWRITE  = tbl[i].wr;
      PWDATA  = tbl[i].d;
      tx_busy = tbl[i].busy;
      clr_ovf = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecount));
      chk($sformatf("tbl%0d_req", i), 32'(tx_wr_en), 32'(tbl[i].ereq));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
      if (tbl[i].ereq) chk($sformatf("tbl%0d_din", i), 32'(tx_din), 32'(tbl[i].edin));
    end

    // Asynchronous reset while a request is pending.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_arst_req", 32'(tx_wr_en), 32'd1);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("arst_tx_wr_en", 32'(tx_wr_en), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    model_reset();
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte with a transmitter that answers after 3 cycles and stays busy 20.
    dut_log.delete();
    tx_delay = 3;
    tx_len   = 20;
    step_tx(1'b1, 8'hA5, 1'b0);
    chk("lat_empty", 32'(empty), 32'd0);
    chk("lat_req_k", 32'(tx_wr_en), 32'd0);
    step_tx(1'b0, 8'h00, 1'b0);
    chk("lat_req_k1", 32'(tx_wr_en), 32'd1);
    chk("lat_din", 32'(tx_din), 32'hA5);
    drain(200);
    chk("lat_log_len", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() == 1) chk("lat_log0", 32'(dut_log[0]), 32'hA5);

    // Burst to full, overflow, clear, then push-with-pop on a full FIFO.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_count", 32'(count), 32'd16);
    chk("burst_ovf", 32'(overflow), 32'd0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_req", 32'(tx_wr_en), 32'd1);
    dut_log.delete();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    tx_delay  = 1;
    tx_len    = 4;
    wait_cnt  = 0;
    busy_left = 0;
    drain(2000);
    chk("burst_log_len", 32'(dut_log.size()), 32'd17);
    if (dut_log.size() == 17) begin
      for (int i = 0; i < DEPTH; i++) chk($sformatf("burst_log%0d", i), 32'(dut_log[i]), 32'(i));
      chk("burst_log16", 32'(dut_log[16]), 32'h55);
    end

    // Clear and overflowing write in the same cycle.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("ovf_vs_clr", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_clr2", 32'(overflow), 32'd0);
    wait_cnt  = 0;
    busy_left = 0;
    drain(2000);

    // Pointer wrap: 40 bytes at random spacing, never overfilling.
    dut_log.delete();
    max_cnt  = 0;
    tx_delay = int'($urandom_range(0, 3));
    tx_len   = int'($urandom_range(2, 6));
    for (int i = 0; i < 40; i++) begin
      int gap;
      int n;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step_tx(1'b0, 8'h00, 1'b0);
      n = 0;
      while (q.size() >= DEPTH && n < 200) begin
        step_tx(1'b0, 8'h00, 1'b0);
        n++;
      end
      step_tx(1'b1, 8'h10 + 8'(i), 1'b0);
    end
    drain(2000);
    chk("wrap_max_count", 32'(max_cnt <= DEPTH), 32'd1);
    chk("wrap_log_len", 32'(dut_log.size()), 32'd40);
    if (dut_log.size() == 40)
      for (int i = 0; i < 40; i++) chk($sformatf("wrap_log%0d", i), 32'(dut_log[i]), 32'h10 + 32'(i));

    // Random traffic including overflows and clears.
    for (int blk = 0; blk < 4; blk++) begin
      tx_delay = int'($urandom_range(0, 4));
      tx_len   = int'($urandom_range(1, 8));
      for (int c = 0; c < 100; c++)
        step_tx(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
    end
    drain(2000);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
